hazard_ctrl: RTL and testbench

- Pipeline hazard controller; the producer side of the ID/EX stage's `ctr_sel` bubble interface.
- Detects load-use hazards between the IF/ID and ID/EX stages, and branch-taken redirects resolved in EX.
- Drives PC write enable, IF/ID write enable, IF/ID flush and `ctr_sel` (1 = pass decoded controls, 0 = insert bubble).
- Multi-cycle stall and flush windows are counter-driven by a small FSM.

---
 rtl/hazard_pkg.sv | 6 +
 rtl/hazard_detect.sv | 17 +
 rtl/hazard_ctrl.sv | 94 +++++++++
 tb/tb_hazard_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
package hazard_pkg;
  typedef enum logic [1:0] {RUN, STALL, FLUSH} hz_state_e;
  localparam int HZ_CNT_W = 4;
  localparam logic [31:0] HZ_NOP = 32'h0000_0013;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator between ID sources and the EX destination.
module hazard_detect #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] i_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs2,
  input  logic                      i_rs1_used,
  input  logic                      i_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd,
  input  logic                      i_reg_write_en,
  input  logic                      i_wb_sel,
  output logic                      o_lu_hit
);
  logic w_src_match;
  assign w_src_match = (i_rs1_used && i_rs1 == i_rd) || (i_rs2_used && i_rs2 == i_rd);
  assign o_lu_hit    = i_wb_sel && i_reg_write_en && (i_rd != '0) && w_src_match;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall and branch flush controller driving PC/IF-ID enables and ctr_sel.
// Optional saturating stall/flush performance counters are enabled by HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
  input  logic                      IF_ID_rs1_used,
  input  logic                      IF_ID_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
  input  logic                      ID_EX_reg_write_en,
  input  logic                      ID_EX_wb_sel,
  input  logic                      EX_branch_taken,
  output logic                      pc_write_en,
  output logic                      IF_ID_write_en,
  output logic                      IF_ID_flush,
  output logic                      ctr_sel,
  output logic                      hz_busy,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);
  localparam logic [HZ_CNT_W-1:0] LS_INIT = HZ_CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [HZ_CNT_W-1:0] FL_INIT = HZ_CNT_W'(FLUSH_CYCLES - 1);
  hz_state_e             r_state, w_nstate;
  logic [HZ_CNT_W-1:0]   r_cnt, w_ncnt;
  logic                  w_lu_hit, w_flush, w_stall;
  hazard_detect #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_detect (
    .i_rs1          (IF_ID_rs1),
    .i_rs2          (IF_ID_rs2),
    .i_rs1_used     (IF_ID_rs1_used),
    .i_rs2_used     (IF_ID_rs2_used),
    .i_rd           (ID_EX_rd),
    .i_reg_write_en (ID_EX_reg_write_en),
    .i_wb_sel       (ID_EX_wb_sel),
    .o_lu_hit       (w_lu_hit)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
    end
  end
  // Branch beats any ongoing window; lu_hit only starts a stall from RUN.
  always_comb begin
    w_nstate = RUN;
    w_ncnt   = '0;
    if (EX_branch_taken) begin
      w_nstate = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      w_ncnt   = FL_INIT;
    end else if (r_state != RUN) begin
      w_nstate = (r_cnt == HZ_CNT_W'(1)) ? RUN : r_state;
      w_ncnt   = r_cnt - HZ_CNT_W'(1);
    end else if (w_lu_hit) begin
      w_nstate = (LOAD_STALL_CYCLES > 1) ? STALL : RUN;
      w_ncnt   = LS_INIT;
    end
  end
  always_comb begin
    w_flush        = !reset && (EX_branch_taken || r_state == FLUSH);
    w_stall        = !reset && !w_flush && (r_state == STALL || (r_state == RUN && w_lu_hit));
    pc_write_en    = !w_stall;
    IF_ID_write_en = !w_stall;
    IF_ID_flush    = w_flush;
    ctr_sel        = !(w_flush || w_stall);
    hz_busy        = !reset && r_state != RUN;
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = {CNT_WIDTH{1'b0}};
  assign flush_cnt = {CNT_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors plus multi-cycle stall/flush/reset sequences on two configurations.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] rs1, rs2, rd;
  logic u1s, u2s, we, wb, br;
  logic pc1, ifwe1, fl1, cs1, bz1, pc3, ifwe3, fl3, cs3, bz3;
  logic [31:0] sc1, fc1, sc3, fc3;
  logic [4:0] o1, o3;
  int vecs = 0;
  int miss = 0;
  localparam logic [4:0] N = 5'b11010, S = 5'b00000, SB = 5'b00001, F = 5'b11100, FB = 5'b11101;
  always #5 clk = ~clk;
  hazard_ctrl u1 (
    .clk(clk), .reset(reset), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .IF_ID_rs1_used(u1s),
    .IF_ID_rs2_used(u2s), .ID_EX_rd(rd), .ID_EX_reg_write_en(we), .ID_EX_wb_sel(wb),
    .EX_branch_taken(br), .pc_write_en(pc1), .IF_ID_write_en(ifwe1), .IF_ID_flush(fl1),
    .ctr_sel(cs1), .hz_busy(bz1), .stall_cnt(sc1), .flush_cnt(fc1)
  );
  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(4)) u3 (
    .clk(clk), .reset(reset), .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .IF_ID_rs1_used(u1s),
    .IF_ID_rs2_used(u2s), .ID_EX_rd(rd), .ID_EX_reg_write_en(we), .ID_EX_wb_sel(wb),
    .EX_branch_taken(br), .pc_write_en(pc3), .IF_ID_write_en(ifwe3), .IF_ID_flush(fl3),
    .ctr_sel(cs3), .hz_busy(bz3), .stall_cnt(sc3), .flush_cnt(fc3)
  );
  assign o1 = {pc1, ifwe1, fl1, cs1, bz1};
  assign o3 = {pc3, ifwe3, fl3, cs3, bz3};
  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       we, wb, br;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic ua, input logic ub,
                       input logic [4:0] d, input logic w, input logic l, input logic j);
    rs1 = a; rs2 = b; u1s = ua; u2s = ub; rd = d; we = w; wb = l; br = j;
  endtask
  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic load5();
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic look();
    @(negedge clk);
  endtask
  initial begin
    tbl[0] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, N};
    tbl[1] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, S};
    tbl[2] = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, N};
    tbl[3] = '{5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, S};
    tbl[4] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, N};
    tbl[5] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, N};
    tbl[6] = '{5'd2, 5'd3, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, F};
    tbl[7] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, F};
    tbl[8] = '{5'd3, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b1, 1'b0, S};
    tbl[9] = '{5'd6, 5'd8, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, N};
    idle();
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd, tbl[i].we, tbl[i].wb, tbl[i].br);
      look();
      chk($sformatf("vec%0d", i), 32'(o1), 32'(tbl[i].exp));
      tick();
    end
    // Reset with a live hazard on the inputs must still show normal outputs.
    reset = 1'b1;
    load5();
    tick();
    look();
    chk("reset_u1", 32'(o1), 32'(N));
    chk("reset_u3", 32'(o3), 32'(N));
    tick();
    reset = 1'b0;
    look();
    chk("lu_c1_u1", 32'(o1), 32'(S));
    chk("lu_c1_u3", 32'(o3), 32'(S));
    tick(); idle(); look();
    chk("lu_c2_u1", 32'(o1), 32'(N));
    chk("lu_c2_u3", 32'(o3), 32'(SB));
    tick(); look();
    chk("lu_c3_u3", 32'(o3), 32'(SB));
    tick(); look();
    chk("lu_c4_u3", 32'(o3), 32'(N));
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt_u1", sc1, 32'd1);
    chk("stall_cnt_u3", sc3, 32'd3);
`else
    chk("stall_cnt_u1", sc1, 32'd0);
    chk("stall_cnt_u3", sc3, 32'd0);
`endif
    tick();
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1);
    look();
    chk("br_lu_u1", 32'(o1), 32'(F));
    chk("br_lu_u3", 32'(o3), 32'(F));
    tick(); idle(); look();
    chk("br_after_u1", 32'(o1), 32'(N));
    for (int c = 2; c <= 4; c++) begin
      chk($sformatf("br_fl%0d_u3", c), 32'(o3), 32'(FB));
      tick(); look();
    end
    chk("br_end_u3", 32'(o3), 32'(N));
    tick();
    load5();
    look();
    chk("abort_c1_u3", 32'(o3), 32'(S));
    tick();
    br = 1'b1;
    look();
    chk("abort_c2_u3", 32'(o3), 32'(FB));
    chk("abort_c2_u1", 32'(o1), 32'(F));
    tick(); idle(); look();
    for (int c = 3; c <= 5; c++) begin
      chk($sformatf("abort_fl%0d_u3", c), 32'(o3), 32'(FB));
      tick(); look();
    end
    chk("abort_end_u3", 32'(o3), 32'(N));
    tick();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    look();
    chk("rstfl_c1_u3", 32'(o3), 32'(F));
    tick(); idle(); look();
    chk("rstfl_c2_u3", 32'(o3), 32'(FB));
    reset = 1'b1;
    #1;
    chk("rstfl_during_u3", 32'(o3), 32'(N));
    tick();
    reset = 1'b0;
    look();
    chk("rstfl_after_u3", 32'(o3), 32'(N));
    chk("rstfl_stall_cnt", sc3, 32'd0);
    chk("rstfl_flush_cnt", fc3, 32'd0);
    chk("rstfl_flush_cnt_u1", fc1, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
